port_uart_tx: RTL
=================

# port_uart_tx

Memory-mapped serial transmit peripheral that sits directly downstream of the port controller. It watches one line of the controller's active-low one-hot write/read select buses. On a write it captures the data-bus byte into a small FIFO; on a read it drives a status byte onto the bus. A UART transmitter drains the FIFO as 8N1 frames on a single serial line.

## Interface
- PORT_ID, 0: which select line (0–15) of `_port_sel_wr`/`_port_sel_rd` addresses this device.
- DEPTH, 4: FIFO depth. Legal values are 2, 4 and 8.
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be ≥2.
- clk  in  1  system clock. Single clock domain.
- _mr  in  1  master reset. Asynchronous, active-low.
- data_in  in  8  CPU data bus, sampled on a write.
- _port_sel_wr  in  16  active-low one-hot write selects from the port controller.
- _port_sel_rd  in  16  active-low one-hot read selects from the port controller.
- data_out  out  8  status byte, valid while `_data_oe` is low.
- _data_oe  out  1  active-low bus drive enable. Combinational copy of `_port_sel_rd[PORT_ID]`.
- tx  out  1  serial output. Idles high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.

## Operation
- Write select (`wr_n = _port_sel_wr[PORT_ID]`):
  - Passes through a 2-flop synchroniser, then a falling-edge detector.
  - Each low pulse yields exactly one push request, whatever its length.
  - `data_in` is captured in the same cycle the edge is detected.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- Read select (`rd_n = _port_sel_rd[PORT_ID]`): synchronised the same way.
  - `data_out` is a registered status snapshot, updated every clock.
  - The synchronised rising edge of `rd_n` (end of read) clears `overflow`.
  - If an overflow event and a clear fall in the same cycle, set wins.
- Status byte layout:
  - bit7 `overflow`
  - bit6 `busy`
  - bit5 `full`
  - bit4 `empty`
  - bits3:0 FIFO count, 0..DEPTH
- TX state machine (IDLE, START, DATA, STOP):
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shifter and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT clocks each. A 3-bit counter tracks the bit index.
  - STOP: `tx` = 1 for CLKS_PER_BIT clocks, then go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and reloads on every state change.
- Select lines other than PORT_ID are ignored.

## Timing
- Reset values:
  - `tx` = 1, `busy` = 0, `data_out` = 8'h10 (empty, count 0), `overflow` = 0.
  - FIFO pointers 0, state IDLE.
  - `_data_oe` still follows `rd_n` during reset.
- Reset is asynchronous and may arrive mid-frame. `tx` returns high immediately and all queued bytes are discarded.
- Push latency:
  - `wr_n` falls → push occurs on clock edge 3 (2 sync + 1 edge detect).
  - The count is visible in `data_out` one clock later.
- `data_in` must be stable from `wr_n` falling until 3 clocks later.
- Minimum low width and minimum high width for both strobes is 3 clocks.
- Pop to `tx` falling (start bit) is 1 clock.
- A frame lasts 10×CLKS_PER_BIT clocks. Back-to-back frames are separated by exactly 1 IDLE clock.
- `busy` rises 1 clock after an accepted push into an idle device. It falls on the first IDLE clock with the FIFO empty.
- Simultaneous push and pop leaves the count unchanged. When the FIFO is full, this case is an accepted push, not an overflow.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full = MSBs differ and lower bits are equal.
  - empty = pointers equal.

## Structure
- Package `port_pkg` holds:
  - the `tx_state_t` enum (IDLE/START/DATA/STOP);
  - status bit-position localparams `ST_OVF`, `ST_BUSY`, `ST_FULL`, `ST_EMPTY`;
  - `ST_COUNT_MSB/LSB`.
- Sub-module `port_fifo`: synchronous FIFO with push, pop, full, empty and count, parameterised by DEPTH.
- The synchroniser/edge detectors and the TX state machine live in the top module.

## Test plan
Bench uses CLKS_PER_BIT=4, DEPTH=4, PORT_ID=2.
- Reset:
  - Assert `_mr`=0 → `tx`=1, `busy`=0.
  - Read `_port_sel_rd`=16'hFFFB → `_data_oe`=0, `data_out`=8'h10.
- Single byte:
  - Write 8'hA5 on `_port_sel_wr`=16'hFFFB for 4 clocks.
  - → `tx` sequence is start 0, then 1,0,1,0,0,1,0,1 (LSB first), then stop 1. Each bit lasts 4 clocks.
  - `busy` falls after 40+ clocks.
- Wrong port: write with `_port_sel_wr`=16'hFFFE → no push; status stays 8'h10 and `tx` stays 1.
- Overflow:
  - Write 6 bytes rapidly while the first frame is in progress → 1 popped, 4 queued, 1 dropped.
  - Status reads 8'hE4 (overflow, busy, full, count 4).
  - After the read strobe deasserts, the next status read shows bit7=0.
- Back-to-back: queue 8'h00 and 8'hFF → stop bit of frame 1, 1 idle clock, then start bit of frame 2. Total 81 clocks from the first start bit.
- Reset mid-frame: assert `_mr` during DATA with 2 bytes queued → `tx`=1 immediately. After release, status is 8'h10 and no further frames are sent.

Source files
------------

// File: rtl/port_pkg.sv
// Shared types and status-byte layout for the port_uart_tx peripheral.
package port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Bit positions inside the status byte driven on reads
  localparam int unsigned ST_OVF       = 7;
  localparam int unsigned ST_BUSY      = 6;
  localparam int unsigned ST_FULL      = 5;
  localparam int unsigned ST_EMPTY     = 4;
  localparam int unsigned ST_COUNT_MSB = 3;
  localparam int unsigned ST_COUNT_LSB = 0;

endpackage

// File: rtl/port_fifo.sv
// Byte FIFO with wrap-bit pointers; the caller guards push/pop against full/empty.
module port_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // Pointer advance; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = 4'(wptr - rptr);

endmodule

// File: rtl/port_uart_tx.sv
// Port-mapped UART transmitter: write strobe queues a byte, read strobe
// returns a status byte, and an 8N1 shifter drains the queue onto tx.
module port_uart_tx
  import port_pkg::*;
#(
  parameter int unsigned PORT_ID      = 0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        _mr,
  input  logic [7:0]  data_in,
  input  logic [15:0] _port_sel_wr,
  input  logic [15:0] _port_sel_rd,
  output logic [7:0]  data_out,
  output logic        _data_oe,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  logic        wr_n;
  logic        rd_n;
  logic [2:0]  wr_sync;
  logic [2:0]  rd_sync;
  logic        wr_fall;
  logic        rd_rise;

  tx_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic        overflow;

  logic        push;
  logic        pop;
  logic [7:0]  fifo_rdata;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic [7:0]  status;

  // Only our select line matters; the rest belong to other peripherals
  logic unused_sel;
  assign unused_sel = &{_port_sel_wr, _port_sel_rd};

  assign wr_n     = _port_sel_wr[PORT_ID];
  assign rd_n     = _port_sel_rd[PORT_ID];
  assign _data_oe = rd_n;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      wr_sync <= '1;
      rd_sync <= '1;
    end else begin
      wr_sync <= {wr_sync[1:0], wr_n};
      rd_sync <= {rd_sync[1:0], rd_n};
    end
  end

  assign wr_fall = wr_sync[2] & ~wr_sync[1];
  assign rd_rise = ~rd_sync[2] & rd_sync[1];

  // A full FIFO still takes a byte when the shifter pops in the same cycle
  assign pop  = (state == IDLE) && !empty;
  assign push = wr_fall && (!full || pop);
  assign busy = !empty || (state != IDLE);

  port_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (_mr),
    .push  (push),
    .wdata (data_in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow: a dropped byte sets it, end of a status read clears it
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      overflow <= 1'b0;
    end else if (wr_fall && full && !pop) begin
      overflow <= 1'b1;
    end else if (rd_rise) begin
      overflow <= 1'b0;
    end
  end

  // Assemble the status byte from the package bit positions
  always_comb begin
    status                            = '0;
    status[ST_OVF]                    = overflow;
    status[ST_BUSY]                   = busy;
    status[ST_FULL]                   = full;
    status[ST_EMPTY]                  = empty;
    status[ST_COUNT_MSB:ST_COUNT_LSB] = count;
  end

  // Registered status snapshot, refreshed every clock
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      data_out <= 8'h10;
    end else begin
      data_out <= status;
    end
  end

  // 8N1 frame sequencer; tx is registered so it changes one clock after pop
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (pop) begin
            shifter <= fifo_rdata;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= shifter[0];
            state <= DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shifter <= {1'b0, shifter[7:1]};
              tx      <= shifter[1];
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
